// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller bus bundle: PC updater, instruction memory, branch redirect and decode hand-off.
// The controller takes the master modport and the surrounding logic takes the slave modport.
interface pc_fetch_ctrl_if #(
  parameter int unsigned IW = 16
);
  logic          en;
  logic [31:0]   pc;
  logic [31:0]   imm;
  logic          ctrl;
  logic [31:0]   pc_new;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [IW-1:0] imem_rdata;
  logic          br_valid;
  logic [31:0]   br_pc;
  logic [31:0]   br_offset;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [31:0]   instr_pc;
  logic          instr_ready;

  modport master (
    input  en, pc_new, imem_gnt, imem_rvalid, imem_rdata, br_valid, br_pc, br_offset,
           instr_ready,
    output pc, imm, ctrl, imem_req, imem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output en, pc_new, imem_gnt, imem_rvalid, imem_rdata, br_valid, br_pc, br_offset,
           instr_ready,
    input  pc, imm, ctrl, imem_req, imem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch controller: owns the architectural PC, issues one 16-bit fetch at a time
// over req/gnt/rvalid and hands each instruction to decode over valid/ready.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IW       = 16
) (
  input logic            clk,
  input logic            rst_n,
  pc_fetch_ctrl_if.master bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StHold = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          drop_q, drop_d;
  logic          instr_valid_q, instr_valid_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [31:0]   instr_pc_q, instr_pc_d;
  logic [1:0]    next_run;

  // The updater computes BR_PC+BR_OFFSET on a redirect, otherwise pc_q+2.
  assign bus.pc   = bus.br_valid ? bus.br_pc : pc_q;
  assign bus.imm  = bus.br_valid ? bus.br_offset : 32'h0;
  assign bus.ctrl = bus.br_valid;

  assign bus.imem_req    = (state_q == StReq);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

  assign next_run = bus.en ? StReq : StIdle;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;

    // A redirect always wins over the sequential update.
    if (bus.br_valid) begin
      pc_d          = bus.pc_new;
      instr_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (!bus.br_valid && bus.en) state_d = StReq;
      end
      StReq: begin
        if (bus.imem_gnt) begin
          state_d = StWait;
          drop_d  = bus.br_valid;
        end
      end
      StWait: begin
        if (bus.br_valid) begin
          if (bus.imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = next_run;
          end else begin
            drop_d = 1'b1;
          end
        end else if (bus.imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = next_run;
          end else begin
            instr_d       = bus.imem_rdata;
            instr_pc_d    = pc_q;
            pc_d          = bus.pc_new;
            instr_valid_d = 1'b1;
            state_d       = StHold;
          end
        end
      end
      StHold: begin
        if (bus.br_valid || bus.instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = next_run;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      drop_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: updater path vectors, directed fetch/branch/reset sequences and a
// randomized run against a transaction-level PC model.
module tb_pc_fetch_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  pc_fetch_ctrl_if #(.IW(16)) bus ();

  pc_fetch_ctrl #(
    .RESET_PC (32'h0000_0100),
    .IW       (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Bench plays the combinational PC updater.
  assign bus.pc_new = bus.ctrl ? (bus.pc + bus.imm) : (bus.pc + 32'd2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br_valid;
    logic [31:0] br_pc;
    logic [31:0] br_offset;
    logic [31:0] exp_pc;
    logic [31:0] exp_imm;
    logic        exp_ctrl;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    return a[16:1] ^ 16'hc3a5;
  endfunction

  task automatic clear_inputs();
    bus.en          = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 16'h0;
    bus.br_valid    = 1'b0;
    bus.br_pc       = 32'h0;
    bus.br_offset   = 32'h0;
    bus.instr_ready = 1'b0;
  endtask

  // Randomized-run state
  logic [31:0] model_pc;
  logic        prev_br, prev_iv, prev_req, prev_gnt;
  logic [31:0] prev_tgt, prev_ipc;
  logic [15:0] prev_instr;
  logic        outstanding;
  logic [31:0] out_addr;
  int          delay;
  int          deliveries;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_inputs();
    rst_n = 1'b0;

    vecs[0] = '{1'b0, 32'h0000_0400, 32'h0000_0010, 32'h0000_0100, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0400, 32'h0000_0010, 32'h0000_0400, 32'h0000_0010, 1'b1};
    vecs[2] = '{1'b1, 32'h0000_0200, 32'hFFFF_FFFC, 32'h0000_0200, 32'hFFFF_FFFC, 1'b1};
    vecs[3] = '{1'b0, 32'hDEAD_BEE0, 32'hFFFF_FFFC, 32'h0000_0100, 32'h0, 1'b0};
    vecs[4] = '{1'b1, 32'hFFFF_FFFE, 32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0002, 1'b1};

    tick();
    tick();
    // Updater outputs are combinational; pc_q is pinned at RESET_PC while in reset.
    for (int i = 0; i < 5; i++) begin
      bus.br_valid  = vecs[i].br_valid;
      bus.br_pc     = vecs[i].br_pc;
      bus.br_offset = vecs[i].br_offset;
      #1;
      chk($sformatf("vec%0d pc", i), bus.pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d imm", i), bus.imm, vecs[i].exp_imm);
      chk($sformatf("vec%0d ctrl", i), 32'(bus.ctrl), 32'(vecs[i].exp_ctrl));
    end
    clear_inputs();
    #1;
    chk("reset imem_req", 32'(bus.imem_req), 32'h0);
    chk("reset instr_valid", 32'(bus.instr_valid), 32'h0);
    chk("reset instr", 32'(bus.instr), 32'h0);
    chk("reset instr_pc", bus.instr_pc, 32'h0);
    chk("reset imem_addr", bus.imem_addr, 32'h100);

    // 1: basic fetch at RESET_PC
    tick();
    rst_n  = 1'b1;
    bus.en = 1'b1;
    tick();
    chk("t1 req", 32'(bus.imem_req), 32'h1);
    chk("t1 addr", bus.imem_addr, 32'h100);
    bus.imem_gnt = 1'b1;
    tick();
    chk("t1 req after gnt", 32'(bus.imem_req), 32'h0);
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 16'hA5A5;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("t1 instr_valid", 32'(bus.instr_valid), 32'h1);
    chk("t1 instr", 32'(bus.instr), 32'hA5A5);
    chk("t1 instr_pc", bus.instr_pc, 32'h100);

    // 2: decode back-pressure holds the instruction and stalls fetch
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2 held valid", 32'(bus.instr_valid), 32'h1);
      chk("t2 held instr", 32'(bus.instr), 32'hA5A5);
      chk("t2 no req", 32'(bus.imem_req), 32'h0);
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk("t2 valid dropped", 32'(bus.instr_valid), 32'h0);
    chk("t2 req", 32'(bus.imem_req), 32'h1);
    chk("t2 next addr", bus.imem_addr, 32'h102);

    // 3: branch while waiting drops the later response
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt  = 1'b0;
    bus.br_valid  = 1'b1;
    bus.br_pc     = 32'h104;
    bus.br_offset = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    bus.en = 1'b1;
    chk("t3 still waiting", 32'(bus.imem_req), 32'h0);
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 16'hDEAD;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("t3 no instr_valid", 32'(bus.instr_valid), 32'h0);
    chk("t3 req", 32'(bus.imem_req), 32'h1);
    chk("t3 addr", bus.imem_addr, 32'h100);

    // 4: branch and response in the same cycle
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 16'hBEEF;
    bus.br_valid    = 1'b1;
    bus.br_pc       = 32'h200;
    bus.br_offset   = 32'h8;
    #1;
    chk("t4 updater pc", bus.pc, 32'h200);
    chk("t4 updater ctrl", 32'(bus.ctrl), 32'h1);
    tick();
    clear_inputs();
    bus.en = 1'b1;
    chk("t4 no instr_valid", 32'(bus.instr_valid), 32'h0);
    chk("t4 req", 32'(bus.imem_req), 32'h1);
    chk("t4 addr", bus.imem_addr, 32'h208);

    // 5: redirect an ungranted request to 0xFFFF_FFFE, then wrap
    bus.br_valid  = 1'b1;
    bus.br_pc     = 32'hFFFF_FFF0;
    bus.br_offset = 32'h0000_000E;
    tick();
    bus.br_valid = 1'b0;
    chk("t5 req kept", 32'(bus.imem_req), 32'h1);
    chk("t5 redirected addr", bus.imem_addr, 32'hFFFF_FFFE);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 16'h1234;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("t5 instr_pc", bus.instr_pc, 32'hFFFF_FFFE);
    chk("t5 instr", 32'(bus.instr), 32'h1234);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk("t5 wrapped addr", bus.imem_addr, 32'h0);

    // 6: asynchronous reset while a fetch is outstanding
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6 req in reset", 32'(bus.imem_req), 32'h0);
    chk("t6 valid in reset", 32'(bus.instr_valid), 32'h0);
    chk("t6 addr in reset", bus.imem_addr, 32'h100);
    tick();
    tick();
    rst_n           = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 16'h7777;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("t6 late rvalid ignored", 32'(bus.instr_valid), 32'h0);
    chk("t6 restart req", 32'(bus.imem_req), 32'h1);
    chk("t6 restart addr", bus.imem_addr, 32'h100);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 16'h5555;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("t6 instr", 32'(bus.instr), 32'h5555);
    chk("t6 instr_pc", bus.instr_pc, 32'h100);

    // Randomized run against a PC model: next PC is +2 per delivered instruction,
    // or the branch target after any redirect.
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n       = 1'b1;
    model_pc    = 32'h100;
    prev_br     = 1'b0;
    prev_iv     = 1'b0;
    prev_req    = 1'b0;
    prev_gnt    = 1'b0;
    prev_tgt    = 32'h0;
    prev_ipc    = 32'h0;
    prev_instr  = 16'h0;
    outstanding = 1'b0;
    out_addr    = 32'h0;
    delay       = 0;
    deliveries  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (prev_br) begin
        model_pc = prev_tgt;
        chk("rnd valid cleared by branch", 32'(bus.instr_valid), 32'h0);
      end else if (bus.instr_valid && !prev_iv) begin
        chk("rnd instr_pc", bus.instr_pc, model_pc);
        chk("rnd instr data", 32'(bus.instr), 32'(mem_word(model_pc)));
        model_pc = model_pc + 32'd2;
        deliveries++;
      end
      if (prev_iv && bus.instr_valid) begin
        chk("rnd held instr", 32'(bus.instr), 32'(prev_instr));
        chk("rnd held instr_pc", bus.instr_pc, prev_ipc);
      end
      if (prev_req && !prev_gnt) chk("rnd req not retracted", 32'(bus.imem_req), 32'h1);
      if (bus.imem_req) chk("rnd fetch addr", bus.imem_addr, model_pc);

      bus.en          = ($urandom_range(0, 7) != 0);
      bus.instr_ready = $urandom_range(0, 1) == 1;
      bus.imem_gnt    = bus.imem_req && ($urandom_range(0, 2) != 0);
      bus.imem_rvalid = 1'b0;
      if (outstanding) begin
        if (delay == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(out_addr);
          outstanding     = 1'b0;
        end else begin
          delay--;
        end
      end
      if (bus.imem_gnt) begin
        outstanding = 1'b1;
        out_addr    = bus.imem_addr;
        delay       = int'($urandom_range(0, 2));
      end
      bus.br_valid = !prev_br && ($urandom_range(0, 11) == 0);
      if (bus.br_valid) begin
        int o;
        o             = int'($urandom_range(0, 64)) - 32;
        bus.br_pc     = $urandom & 32'hFFFF_FFFE;
        bus.br_offset = 32'(o * 2);
      end
      #1;
      if (bus.br_valid) begin
        chk("rnd updater pc", bus.pc, bus.br_pc);
        chk("rnd updater imm", bus.imm, bus.br_offset);
      end else begin
        chk("rnd updater seq imm", bus.imm, 32'h0);
      end

      prev_br    = bus.br_valid;
      prev_tgt   = bus.br_pc + bus.br_offset;
      prev_iv    = bus.instr_valid;
      prev_instr = bus.instr;
      prev_ipc   = bus.instr_pc;
      prev_req   = bus.imem_req;
      prev_gnt   = bus.imem_gnt;
    end
    n_checks++;
    if (deliveries < 50) begin
      n_fail++;
      $display("FAIL rnd progress: %0d deliveries, expected at least 50", deliveries);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
